ppu_pack: RTL and testbench

PPU_PACK -- requirements
Module: ppu_pack

---
 rtl/ppu_pack_if.sv | 27 ++
 rtl/ppu_pack.sv | 120 ++++++++++++
 tb/tb_ppu_pack.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ppu_pack_if.sv
// Streaming interface for ppu_pack: row start/config, opsum input stream,
// packed ofmap output stream and busy status.
interface ppu_pack_if #(
    parameter int DATA_BITS = 32
);
    logic                 ppu_en;
    logic [4:0]           cfg_shift;
    logic [7:0]           cfg_len;
    logic [DATA_BITS-1:0] opsum;
    logic                 opsum_valid;
    logic                 opsum_ready;
    logic [DATA_BITS-1:0] ofmap;
    logic                 ofmap_valid;
    logic                 ofmap_ready;
    logic                 ofmap_last;
    logic                 busy;

    modport master (
        output ppu_en, cfg_shift, cfg_len, opsum, opsum_valid, ofmap_ready,
        input  opsum_ready, ofmap, ofmap_valid, ofmap_last, busy
    );

    modport slave (
        input  ppu_en, cfg_shift, cfg_len, opsum, opsum_valid, ofmap_ready,
        output opsum_ready, ofmap, ofmap_valid, ofmap_last, busy
    );
endinterface

// File: rtl/ppu_pack.sv
// Requantizes signed opsums (round-half-up shift, int8 saturate, +0x80 offset)
// and packs four uint8 results per ofmap word. Define PPU_RELU_EN to clamp negatives to 0.
module ppu_pack #(
    parameter int DATA_BITS = 32
) (
    input  logic        clk,
    input  logic        rst,
    ppu_pack_if.slave   bus
);
    localparam int WB = DATA_BITS + 1;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] COLLECT = 2'd1;
    localparam logic [1:0] SEND    = 2'd2;

    localparam logic signed [WB-1:0] SAT_HI = WB'(127);
    localparam logic signed [WB-1:0] SAT_LO = WB'(-128);

    logic [1:0]           state_reg;
    logic [4:0]           shift_reg;
    logic [7:0]           len_reg;
    logic [1:0]           byte_cnt_reg;
    logic [7:0]           elem_cnt_reg;
    logic [DATA_BITS-1:0] lane_reg;
    logic                 last_reg;

    logic                 accept;
    logic                 is_last_elem;
    logic                 word_done;
    logic signed [WB-1:0] rnd_val;
    logic signed [WB-1:0] t_val;
    logic signed [WB-1:0] r_val;
    logic [7:0]           sat_byte;
    logic [7:0]           byte_val;
    logic [DATA_BITS-1:0] lane_next;

    assign bus.opsum_ready = (state_reg == COLLECT);
    assign bus.ofmap_valid = (state_reg == SEND);
    assign bus.ofmap       = (state_reg == SEND) ? lane_reg : '0;
    assign bus.ofmap_last  = (state_reg == SEND) & last_reg;
    assign bus.busy        = (state_reg != IDLE);

    assign accept       = bus.opsum_valid & bus.opsum_ready;
    // len_reg of 0 encodes 256, so len-1 wraps naturally to 255.
    assign is_last_elem = (elem_cnt_reg == (len_reg - 8'd1));
    assign word_done    = (byte_cnt_reg == 2'd3) | is_last_elem;

    always_comb begin
        rnd_val = '0;
        if (shift_reg != 5'd0)
            rnd_val = WB'(1) << (shift_reg - 5'd1);
        t_val = $signed({bus.opsum[DATA_BITS-1], bus.opsum}) + rnd_val;
        r_val = t_val >>> shift_reg;
`ifdef PPU_RELU_EN
        if (r_val < 0)
            r_val = '0;
`endif
        if (r_val > SAT_HI)
            sat_byte = 8'h7F;
        else if (r_val < SAT_LO)
            sat_byte = 8'h80;
        else
            sat_byte = r_val[7:0];
        byte_val = sat_byte ^ 8'h80;
    end

    // Only the lane addressed by byte_cnt takes the new byte.
    generate
        for (genvar gi = 0; gi < DATA_BITS / 8; gi++) begin : g_lane
            assign lane_next[gi*8 +: 8] = (byte_cnt_reg == 2'(gi)) ? byte_val
                                                                    : lane_reg[gi*8 +: 8];
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            shift_reg    <= '0;
            len_reg      <= '0;
            byte_cnt_reg <= '0;
            elem_cnt_reg <= '0;
            lane_reg     <= '0;
            last_reg     <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.ppu_en) begin
                        shift_reg    <= bus.cfg_shift;
                        len_reg      <= bus.cfg_len;
                        byte_cnt_reg <= '0;
                        elem_cnt_reg <= '0;
                        lane_reg     <= '0;
                        last_reg     <= 1'b0;
                        state_reg    <= COLLECT;
                    end
                end
                COLLECT: begin
                    if (accept) begin
                        lane_reg     <= lane_next;
                        byte_cnt_reg <= byte_cnt_reg + 2'd1;
                        elem_cnt_reg <= elem_cnt_reg + 8'd1;
                        if (word_done) begin
                            last_reg  <= is_last_elem;
                            state_reg <= SEND;
                        end
                    end
                end
                SEND: begin
                    if (bus.ofmap_ready) begin
                        lane_reg     <= '0;
                        byte_cnt_reg <= '0;
                        last_reg     <= 1'b0;
                        state_reg    <= last_reg ? IDLE : COLLECT;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ppu_pack.sv
// Directed-vector bench for ppu_pack: table of rows plus backpressure, reset,
// ignored-start and 256-element sequences.
module tb_ppu_pack;
    logic clk;
    logic rst;

    ppu_pack_if #(.DATA_BITS(32)) bus ();

    ppu_pack #(.DATA_BITS(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests;
    int fails;

    typedef struct packed {
        logic [4:0]       shift;
        logic [7:0]       len;
        logic [3:0]       n;
        logic [4:0][31:0] ops;
        logic [1:0]       nw;
        logic [1:0][31:0] words;
        logic [1:0]       lasts;
    } vec_t;

    vec_t vecs[6];

    // Protocol rules watched on every cycle outside reset.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.ofmap_valid && bus.opsum_ready) begin
                fails++;
                $display("FAIL valid_ready_overlap got both high, required not both");
            end
            if (!bus.ofmap_valid && bus.ofmap != 32'h0) begin
                fails++;
                $display("FAIL ofmap_idle_zero got %08h, required 00000000", bus.ofmap);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got %08h, required %08h", nm, got, exp);
        end
    endtask

    task automatic start_row(input logic [4:0] sh, input logic [7:0] ln);
        bus.ppu_en    = 1'b1;
        bus.cfg_shift = sh;
        bus.cfg_len   = ln;
        step();
        bus.ppu_en    = 1'b0;
        bus.cfg_shift = 5'h1F;
        bus.cfg_len   = 8'h01;
    endtask

    task automatic send_opsum(input logic [31:0] v);
        int cnt;
        cnt = 0;
        bus.opsum       = v;
        bus.opsum_valid = 1'b1;
        while (!bus.opsum_ready && cnt < 50) begin
            step();
            cnt++;
        end
        if (!bus.opsum_ready) begin
            tests++;
            fails++;
            $display("FAIL opsum_ready_timeout got 0, required 1");
        end
        step();
        bus.opsum_valid = 1'b0;
        bus.opsum       = 32'hDEADBEEF;
    endtask

    task automatic recv_word(input string nm, input logic [31:0] ew, input logic el);
        int cnt;
        cnt = 0;
        while (!bus.ofmap_valid && cnt < 50) begin
            step();
            cnt++;
        end
        if (!bus.ofmap_valid) begin
            tests++;
            fails++;
            $display("FAIL %s_valid_timeout got 0, required 1", nm);
        end
        chk({nm, "_word"}, bus.ofmap, ew);
        chk({nm, "_last"}, 32'(bus.ofmap_last), 32'(el));
        bus.ofmap_ready = 1'b1;
        step();
        bus.ofmap_ready = 1'b0;
    endtask

    task automatic add_vec(input int i, input logic [4:0] sh, input logic [7:0] ln,
                           input int n, input logic [31:0] o0, input logic [31:0] o1,
                           input logic [31:0] o2, input logic [31:0] o3, input logic [31:0] o4,
                           input int nw, input logic [31:0] w0, input logic [31:0] w1,
                           input logic l0, input logic l1);
        vecs[i].shift    = sh;
        vecs[i].len      = ln;
        vecs[i].n        = 4'(n);
        vecs[i].ops[0]   = o0;
        vecs[i].ops[1]   = o1;
        vecs[i].ops[2]   = o2;
        vecs[i].ops[3]   = o3;
        vecs[i].ops[4]   = o4;
        vecs[i].nw       = 2'(nw);
        vecs[i].words[0] = w0;
        vecs[i].words[1] = w1;
        vecs[i].lasts[0] = l0;
        vecs[i].lasts[1] = l1;
    endtask

    initial begin
        logic [31:0] exp_w;
        int          wi;
        logic        seen;

        tests = 0;
        fails = 0;
        rst             = 1'b1;
        bus.ppu_en      = 1'b0;
        bus.cfg_shift   = 5'd0;
        bus.cfg_len     = 8'd0;
        bus.opsum       = 32'h0;
        bus.opsum_valid = 1'b0;
        bus.ofmap_ready = 1'b0;

        add_vec(0, 5'd0,  8'd4, 4, 32'd1, 32'd2, 32'd3, 32'd4, 32'd0,
                1, 32'h84838281, 32'h0, 1'b1, 1'b0);
`ifdef PPU_RELU_EN
        add_vec(1, 5'd2,  8'd2, 2, 32'd6, -32'sd6, 32'd0, 32'd0, 32'd0,
                1, 32'h00008082, 32'h0, 1'b1, 1'b0);
        add_vec(2, 5'd0,  8'd2, 2, 32'd1000, -32'sd1000, 32'd0, 32'd0, 32'd0,
                1, 32'h000080FF, 32'h0, 1'b1, 1'b0);
`else
        add_vec(1, 5'd2,  8'd2, 2, 32'd6, -32'sd6, 32'd0, 32'd0, 32'd0,
                1, 32'h00007F82, 32'h0, 1'b1, 1'b0);
        add_vec(2, 5'd0,  8'd2, 2, 32'd1000, -32'sd1000, 32'd0, 32'd0, 32'd0,
                1, 32'h000000FF, 32'h0, 1'b1, 1'b0);
`endif
        add_vec(3, 5'd0,  8'd5, 5, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0,
                2, 32'h80808080, 32'h00000080, 1'b0, 1'b1);
        add_vec(4, 5'd1,  8'd3, 3, 32'd1, -32'sd1, 32'd3, 32'd0, 32'd0,
                1, 32'h00828081, 32'h0, 1'b1, 1'b0);
        add_vec(5, 5'd31, 8'd1, 1, 32'h7FFFFFFF, 32'd0, 32'd0, 32'd0, 32'd0,
                1, 32'h00000081, 32'h0, 1'b1, 1'b0);

        // Reset state
        #1;
        chk("rst_opsum_ready", 32'(bus.opsum_ready), 32'd0);
        chk("rst_ofmap",       bus.ofmap,            32'd0);
        chk("rst_ofmap_valid", 32'(bus.ofmap_valid), 32'd0);
        chk("rst_ofmap_last",  32'(bus.ofmap_last),  32'd0);
        chk("rst_busy",        32'(bus.busy),        32'd0);
        step();
        step();
        rst = 1'b0;
        step();

        for (int v = 0; v < 6; v++) begin
            start_row(vecs[v].shift, vecs[v].len);
            chk($sformatf("v%0d_busy_start", v), 32'(bus.busy), 32'd1);
            wi = 0;
            for (int e = 0; e < int'(vecs[v].n); e++) begin
                send_opsum(vecs[v].ops[e]);
                if ((e % 4) == 3 || e == int'(vecs[v].n) - 1) begin
                    recv_word($sformatf("v%0d_w%0d", v, wi), vecs[v].words[wi], vecs[v].lasts[wi]);
                    wi++;
                end
            end
            chk($sformatf("v%0d_words", v), 32'(wi), 32'(vecs[v].nw));
            chk($sformatf("v%0d_busy_end", v), 32'(bus.busy), 32'd0);
            $display("[TB] vector %0d done", v);
        end

        // Backpressure: word held for three cycles, accepted on the fourth
        start_row(5'd0, 8'd1);
        send_opsum(32'd5);
        for (int c = 0; c < 3; c++) begin
            chk("bp_valid",       32'(bus.ofmap_valid), 32'd1);
            chk("bp_word",        bus.ofmap,            32'h00000085);
            chk("bp_opsum_ready", 32'(bus.opsum_ready), 32'd0);
            step();
        end
        chk("bp_valid_4th", 32'(bus.ofmap_valid), 32'd1);
        bus.ofmap_ready = 1'b1;
        step();
        bus.ofmap_ready = 1'b0;
        chk("bp_valid_after", 32'(bus.ofmap_valid), 32'd0);
        chk("bp_busy_after",  32'(bus.busy),        32'd0);
        $display("[TB] backpressure sequence done");

        // ppu_en during COLLECT must not reload config
        start_row(5'd0, 8'd2);
        bus.ppu_en    = 1'b1;
        bus.cfg_shift = 5'd3;
        bus.cfg_len   = 8'd1;
        step();
        bus.ppu_en    = 1'b0;
        send_opsum(32'd10);
        send_opsum(32'd20);
        recv_word("ign_en", 32'h0000948A, 1'b1);
        chk("ign_en_busy", 32'(bus.busy), 32'd0);
        $display("[TB] ignored ppu_en sequence done");

        // Reset mid-row
        start_row(5'd0, 8'd4);
        send_opsum(32'd1);
        send_opsum(32'd2);
        rst = 1'b1;
        #1;
        chk("mrst_opsum_ready", 32'(bus.opsum_ready), 32'd0);
        chk("mrst_ofmap",       bus.ofmap,            32'd0);
        chk("mrst_ofmap_valid", 32'(bus.ofmap_valid), 32'd0);
        chk("mrst_ofmap_last",  32'(bus.ofmap_last),  32'd0);
        chk("mrst_busy",        32'(bus.busy),        32'd0);
        step();
        rst = 1'b0;
        bus.opsum       = 32'd3;
        bus.opsum_valid = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (bus.ofmap_valid || bus.busy) seen = 1'b1;
            step();
        end
        bus.opsum_valid = 1'b0;
        chk("mrst_no_output", 32'(seen), 32'd0);
        start_row(5'd0, 8'd1);
        send_opsum(32'd7);
        recv_word("mrst_recover", 32'h00000087, 1'b1);
        $display("[TB] mid-row reset sequence done");

        // cfg_len=0 means 256 elements: 64 words, last only on the final one
        start_row(5'd0, 8'd0);
        wi = 0;
        for (int e = 0; e < 256; e++) begin
            send_opsum(32'd0);
            if ((e % 4) == 3) begin
                exp_w = 32'h80808080;
                recv_word($sformatf("len256_w%0d", wi), exp_w, (wi == 63));
                wi++;
            end
        end
        chk("len256_busy_end", 32'(bus.busy), 32'd0);
        $display("[TB] len=256 sequence done, %0d words", wi);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
